// File: rtl/mark_sched.sv
// Round-robin scheduler sharing NCH marker-window generators between NREQ requesters.
// Issues a one-cycle strobe plus a shared 64-bit command and tracks per-channel busy windows.
module mark_sched #(
    parameter int NREQ = 4,
    parameter int NCH  = 4,
    parameter int CW   = 4,
    parameter int LAT  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*CW-1:0]   req_chan,
    input  logic [NREQ*12-1:0]   req_start,
    input  logic [NREQ*12-1:0]   req_len,
    output logic [NREQ-1:0]      req_ready,
    output logic [NCH-1:0]       mk_stb,
    output logic [63:0]          mk_cmd,
    output logic [NCH-1:0]       ch_busy,
    output logic                 err_badchan,
    input  logic                 err_clr
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]  r_ptr;
    logic [NCH-1:0] r_stb;
    logic [63:0]    r_cmd;
    logic           r_err;
    logic [13:0]    r_cnt [NCH];

    logic [NCH-1:0]  w_busy;
    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [PW-1:0]   w_gntIdx;
    logic [CW-1:0]   w_selChan;
    logic [11:0]     w_selStart;
    logic [11:0]     w_selLen;
    logic            w_chanOk;
    logic            w_issue;
    logic            w_bad;
    logic [13:0]     w_load;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_busy[c] = (r_cnt[c] != 14'd0);
        end
    end

    // Out-of-range channels never match a generator, so they stay eligible and never stall.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_valid[i];
            for (int c = 0; c < NCH; c++) begin
                if (int'(req_chan[i*CW +: CW]) == c && (w_busy[c] || r_stb[c])) begin
                    w_elig[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin : arb
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_gntIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_found && w_elig[idx]) begin
                w_found  = 1'b1;
                w_gntIdx = PW'(idx);
            end
        end
    end

    assign req_ready  = (rstn && w_found) ? (NREQ'(1) << w_gntIdx) : '0;
    assign w_selChan  = req_chan[int'(w_gntIdx)*CW +: CW];
    assign w_selStart = req_start[int'(w_gntIdx)*12 +: 12];
    assign w_selLen   = req_len[int'(w_gntIdx)*12 +: 12];
    assign w_chanOk   = int'(w_selChan) < NCH;
    assign w_issue    = w_found && w_chanOk;
    assign w_bad      = w_found && !w_chanOk;
    assign w_load     = 14'(w_selStart) + 14'(w_selLen) + 14'(LAT);

    // Strobe, busy counters and command all launch on the edge that closes the handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
            r_stb <= '0;
            r_cmd <= '0;
            r_err <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                r_stb[c] <= w_issue && (int'(w_selChan) == c);
                if (w_issue && (int'(w_selChan) == c)) begin
                    r_cnt[c] <= w_load;
                end else if (r_cnt[c] != 14'd0) begin
                    r_cnt[c] <= r_cnt[c] - 14'd1;
                end
            end
            if (w_issue) begin
                r_cmd <= {2'b00, w_selStart, w_selLen, 38'd0};
            end
            if (w_bad) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (w_found) begin
                r_ptr <= (int'(w_gntIdx) == NREQ - 1) ? '0 : w_gntIdx + PW'(1);
            end
        end
    end

    assign mk_stb      = r_stb;
    assign mk_cmd      = r_cmd;
    assign ch_busy     = w_busy;
    assign err_badchan = r_err;

endmodule

// File: tb/tb_mark_sched.sv
// Scoreboard bench for mark_sched: a cycle-level model predicts grants and busy windows,
// queues expected strobes, and a negedge monitor pops and compares them.
module tb_mark_sched;

    localparam int NREQ = 4;
    localparam int NCH  = 4;
    localparam int CW   = 4;
    localparam int LAT  = 4;

    logic                clk;
    logic                rstn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*CW-1:0]  req_chan;
    logic [NREQ*12-1:0]  req_start;
    logic [NREQ*12-1:0]  req_len;
    logic [NREQ-1:0]     req_ready;
    logic [NCH-1:0]      mk_stb;
    logic [63:0]         mk_cmd;
    logic [NCH-1:0]      ch_busy;
    logic                err_badchan;
    logic                err_clr;

    mark_sched #(.NREQ(NREQ), .NCH(NCH), .CW(CW), .LAT(LAT)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_chan(req_chan),
        .req_start(req_start), .req_len(req_len), .req_ready(req_ready),
        .mk_stb(mk_stb), .mk_cmd(mk_cmd), .ch_busy(ch_busy),
        .err_badchan(err_badchan), .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        int          ch;
        logic [63:0] cmd;
    } exp_t;

    exp_t expQ[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Requester-side pending requests
    bit pv [NREQ];
    int pch[NREQ];
    int pst[NREQ];
    int pln[NREQ];
    bit errClr;

    // Reference model state: absolute cycle numbers of window ends and strobes
    int          mPtr;
    int          busyUntil[NCH];
    int          stbAt[NCH];
    logic [63:0] lastCmd, cmdNext;
    bit          errExp, errNext;
    int          dutGrant[NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic driveInputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = pv[i];
            req_chan[i*CW +: CW]   = CW'(pch[i]);
            req_start[i*12 +: 12]  = 12'(pst[i]);
            req_len[i*12 +: 12]    = 12'(pln[i]);
        end
        err_clr = errClr;
    endtask

    task automatic modelReset();
        mPtr    = 0;
        lastCmd = '0;
        cmdNext = '0;
        errExp  = 1'b0;
        errNext = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            busyUntil[c] = -1000;
            stbAt[c]     = -1000;
        end
        for (int i = 0; i < NREQ; i++) begin
            pv[i]       = 1'b0;
            dutGrant[i] = -1;
        end
        errClr = 1'b0;
        expQ.delete();
    endtask

    task automatic checkOutput();
        int win;
        logic [NREQ-1:0] expRdy;
        logic [NCH-1:0]  expBusy;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (mPtr + k) % NREQ;
            if (win < 0 && pv[i]) begin
                if (pch[i] >= NCH) begin
                    win = i;
                end else if (cyc > busyUntil[pch[i]] && stbAt[pch[i]] != cyc) begin
                    win = i;
                end
            end
        end
        expRdy = '0;
        if (win >= 0) expRdy[win] = 1'b1;
        for (int c = 0; c < NCH; c++) expBusy[c] = (cyc <= busyUntil[c]);
        check("ready", 64'(req_ready), 64'(expRdy));
        check("busy", 64'(ch_busy), 64'(expBusy));
        check("err", 64'(err_badchan), 64'(errExp));
        check("cmd", mk_cmd, lastCmd);
        cmdNext = lastCmd;
        errNext = errClr ? 1'b0 : errExp;
        if (win >= 0) begin
            if (pch[win] < NCH) begin
                exp_t e;
                e.cyc = cyc + 1;
                e.ch  = pch[win];
                e.cmd = {2'b00, 12'(pst[win]), 12'(pln[win]), 38'd0};
                expQ.push_back(e);
                busyUntil[pch[win]] = cyc + pst[win] + pln[win] + LAT;
                stbAt[pch[win]]     = cyc + 1;
                cmdNext             = e.cmd;
            end else begin
                errNext = 1'b1;
            end
            mPtr    = (win + 1) % NREQ;
            pv[win] = 1'b0;
        end
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+4
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        cyc++;
        lastCmd = cmdNext;
        errExp  = errNext;
        driveInputs();
        #3;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) dutGrant[i] = cyc;
        end
        checkOutput();
    endtask

    task automatic resetDut();
        rstn = 1'b0;
        #1;
        check("rst_stb", 64'(mk_stb), 64'd0);
        check("rst_cmd", mk_cmd, 64'd0);
        check("rst_busy", 64'(ch_busy), 64'd0);
        check("rst_err", 64'(err_badchan), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        driveInputs();
        #1;
        rstn = 1'b1;
    endtask

    task automatic setReq(input int i, input int ch, input int st, input int ln);
        pv[i]  = 1'b1;
        pch[i] = ch;
        pst[i] = st;
        pln[i] = ln;
    endtask

    // Monitor: every strobe must match the oldest queued issue for that cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                    check("stb_missing", 64'(expQ[0].cyc), 64'(cyc));
                    void'(expQ.pop_front());
                end
                if (mk_stb != '0) begin
                    if (expQ.size() == 0 || expQ[0].cyc != cyc) begin
                        check("stb_unexpected", 64'(mk_stb), 64'd0);
                    end else begin
                        exp_t e;
                        logic [NCH-1:0] oh;
                        e  = expQ.pop_front();
                        oh = '0;
                        oh[e.ch] = 1'b1;
                        check("stb", 64'(mk_stb), 64'(oh));
                        check("stb_cmd", mk_cmd, e.cmd);
                    end
                end
            end
        end
    end

    initial begin
        int cnt;
        rstn      = 1'b1;
        req_valid = '0;
        req_chan  = '0;
        req_start = '0;
        req_len   = '0;
        err_clr   = 1'b0;
        modelReset();
        #2;
        req_valid = '1;
        resetDut();

        // Round robin from pointer 0 across distinct channels
        for (int i = 0; i < NREQ; i++) setReq(i, i, 0, 0);
        for (int k = 0; k < NREQ; k++) begin
            applyStimulus();
            check("rr_grant", 64'(req_ready), 64'(4'b0001 << k));
        end
        repeat (8) applyStimulus();

        // Single issue: busy for 10+5+LAT cycles
        setReq(0, 2, 10, 5);
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            applyStimulus();
            if (ch_busy[2]) cnt++;
        end
        check("single_busy_len", 64'(cnt), 64'd19);

        // Busy hold-off on channel 1
        setReq(0, 1, 0, 0);
        applyStimulus();
        setReq(1, 1, 3, 4);
        repeat (8) applyStimulus();
        check("holdoff_gap", 64'(dutGrant[1] - dutGrant[0]), 64'd5);
        repeat (14) applyStimulus();

        // Contention on channel 3 with pointer at 2
        setReq(1, 3, 2, 3);
        setReq(3, 3, 2, 3);
        repeat (15) applyStimulus();
        check("contend_order", 64'(dutGrant[3] < dutGrant[1]), 64'd1);
        check("contend_gap", 64'(dutGrant[1] - dutGrant[3]), 64'd10);

        // Bad channel, clear, then clear racing a new set
        setReq(2, 9, 1, 1);
        repeat (3) applyStimulus();
        check("bad_err_set", 64'(err_badchan), 64'd1);
        errClr = 1'b1;
        applyStimulus();
        errClr = 1'b0;
        applyStimulus();
        check("bad_err_clr", 64'(err_badchan), 64'd0);
        setReq(2, 9, 2, 2);
        errClr = 1'b1;
        applyStimulus();
        errClr = 1'b0;
        applyStimulus();
        check("bad_err_race", 64'(err_badchan), 64'd1);

        // Reset while channel 0 has a long window in flight
        setReq(0, 0, 20, 20);
        repeat (5) applyStimulus();
        resetDut();
        setReq(0, 0, 3, 3);
        applyStimulus();
        check("post_rst_grant", 64'(req_ready), 64'd1);
        repeat (12) applyStimulus();

        // Randomized traffic, including out-of-range channels and err_clr
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    setReq(i, int'($urandom_range(0, 5)), int'($urandom_range(0, 12)),
                           int'($urandom_range(0, 12)));
                end
            end
            errClr = ($urandom_range(0, 9) == 0);
            applyStimulus();
        end
        errClr = 1'b0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        repeat (40) applyStimulus();
        check("queue_drained", 64'(expQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
